rst_seq_ctrl: RTL and testbench

//  Staged reset release sequencer. It consumes the already-synchronized board reset and a soft-reset request.
//  It drives NUM_STAGES per-domain active-low resets, released in order (stage 0 first) with programmable gaps.

---
 rtl/rst_seq_pkg.sv | 22 ++
 rtl/rst_seq_if.sv | 26 ++
 rtl/rst_seq_cnt.sv | 28 ++
 rtl/rst_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_rst_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration helpers for the staged reset sequencer.
// Optional watchdog: RST_SEQ_WDOG_EN (see rst_seq_ctrl).
package rst_seq_pkg;

   typedef enum logic [1:0] {
      S_HOLD = 2'd0,
      S_REL  = 2'd1,
      S_RUN  = 2'd2
   } state_e;

   localparam int MAX_STAGES = 8;

   // The counters only ever reach (limit-1), so the largest limit must stay below 2**cnt_w.
   function automatic logic cnt_w_ok(input int cnt_w, input int hold, input int gap, input int wdog);
      longint m;
      m = longint'(hold);
      if (longint'(gap) > m) m = longint'(gap);
      if (longint'(wdog) > m) m = longint'(wdog);
      return (cnt_w >= 1) && (cnt_w <= 62) && (m < (longint'(1) << cnt_w));
   endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Request/status bundle between the reset sequencer (slave) and its controller (master).
// wdog_kick exists only when RST_SEQ_WDOG_EN is defined.
interface rst_seq_if #(parameter int NUM_STAGES = 3);

   // soft_rst_req is a level: every cycle it is sampled high produces one soft_rst_ack pulse,
   // no ready/backpressure; stage_rst_n/seq_busy/seq_done are registered status outputs.
   logic                  soft_rst_req;
   logic                  soft_rst_ack;
   logic [NUM_STAGES-1:0] stage_rst_n;
   logic                  seq_busy;
   logic                  seq_done;
`ifdef RST_SEQ_WDOG_EN
   logic                  wdog_kick;

   modport master (output soft_rst_req, output wdog_kick,
                   input  soft_rst_ack, input stage_rst_n, input seq_busy, input seq_done);
   modport slave  (input  soft_rst_req, input wdog_kick,
                   output soft_rst_ack, output stage_rst_n, output seq_busy, output seq_done);
`else
   modport master (output soft_rst_req,
                   input  soft_rst_ack, input stage_rst_n, input seq_busy, input seq_done);
   modport slave  (input  soft_rst_req,
                   output soft_rst_ack, output stage_rst_n, output seq_busy, output seq_done);
`endif

endinterface

// File: rtl/rst_seq_cnt.sv
// Up-counter with synchronous clear, enable and a terminal-match flag.
module rst_seq_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] term,
   output logic             hit
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)     cnt_d = '0;
      else if (en) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign hit = (cnt_q == term);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staged reset release sequencer: holds all stages, then releases stage 0..N-1 at fixed gaps.
// Define RST_SEQ_WDOG_EN to add the S_RUN watchdog that restarts the sequence when not kicked.
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int NUM_STAGES  = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 8,
   parameter int CNT_W       = 8,
   parameter int WDOG_CYCLES = 200
) (
   input  logic     clk,
   input  logic     rst_n,
   rst_seq_if.slave bus
);

   if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
      $error("rst_seq_ctrl: NUM_STAGES must be 1..8");
   end
   if (HOLD_CYCLES < 1 || STAGE_GAP < 1) begin : g_bad_timing
      $error("rst_seq_ctrl: HOLD_CYCLES and STAGE_GAP must be >= 1");
   end
   if (!cnt_w_ok(CNT_W, HOLD_CYCLES, STAGE_GAP, WDOG_CYCLES)) begin : g_bad_cnt_w
      $error("rst_seq_ctrl: CNT_W too narrow for the configured cycle counts");
   end

   localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(STAGE_GAP - 1);
   localparam logic [3:0]       LAST_STG  = 4'(NUM_STAGES - 1);

   state_e                state_q, state_d;
   logic [3:0]            stg_q, stg_d;
   logic [NUM_STAGES-1:0] stage_q, stage_d;
   logic                  busy_q, busy_d;
   logic                  ack_q, ack_d;
   logic                  done_q, done_d;

   logic                  restart;
   logic                  wdog_trip;
   logic                  tmr_hit;
   logic [CNT_W-1:0]      tmr_term;

   assign restart  = bus.soft_rst_req | wdog_trip;
   assign tmr_term = (state_q == S_HOLD) ? HOLD_TERM : GAP_TERM;

   // One timer serves both the initial hold and every inter-stage gap.
   rst_seq_cnt #(.CNT_W(CNT_W)) u_tmr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (restart | tmr_hit | (state_q == S_RUN)),
      .en    (state_q != S_RUN),
      .term  (tmr_term),
      .hit   (tmr_hit)
   );

`ifdef RST_SEQ_WDOG_EN
   localparam logic [CNT_W-1:0] WDOG_TERM = CNT_W'(WDOG_CYCLES - 1);
   logic wdog_hit;

   rst_seq_cnt #(.CNT_W(CNT_W)) u_wdog (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.wdog_kick | restart | (state_q != S_RUN)),
      .en    (state_q == S_RUN),
      .term  (WDOG_TERM),
      .hit   (wdog_hit)
   );

   assign wdog_trip = (state_q == S_RUN) & wdog_hit & ~bus.wdog_kick;
`else
   assign wdog_trip = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      stg_d   = stg_q;
      stage_d = stage_q;
      ack_d   = 1'b0;
      done_d  = 1'b0;
      if (restart) begin
         // A request outranks a coincident last-stage release, so done never pairs with ack.
         state_d = S_HOLD;
         stg_d   = 4'd0;
         stage_d = '0;
         ack_d   = 1'b1;
      end else begin
         case (state_q)
            S_HOLD: begin
               if (tmr_hit) begin
                  stage_d[0] = 1'b1;
                  stg_d      = 4'd1;
                  state_d    = (NUM_STAGES == 1) ? S_RUN : S_REL;
                  done_d     = (NUM_STAGES == 1);
               end
            end
            S_REL: begin
               if (tmr_hit) begin
                  for (int i = 0; i < NUM_STAGES; i++) begin
                     if (stg_q == 4'(i)) stage_d[i] = 1'b1;
                  end
                  stg_d = stg_q + 4'd1;
                  if (stg_q == LAST_STG) begin
                     state_d = S_RUN;
                     done_d  = 1'b1;
                  end
               end
            end
            S_RUN:   ;
            default: state_d = S_HOLD;
         endcase
      end
      busy_d = ~(&stage_d);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_HOLD;
         stg_q   <= 4'd0;
         stage_q <= '0;
         busy_q  <= 1'b1;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stg_q   <= stg_d;
         stage_q <= stage_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   assign bus.stage_rst_n  = stage_q;
   assign bus.seq_busy     = busy_q;
   assign bus.seq_done     = done_q;
   assign bus.soft_rst_ack = ack_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed scenarios plus random requests/resets against a timeline model.
// Watchdog scenario is built only when RST_SEQ_WDOG_EN is defined.
module tb_rst_seq_ctrl;

   localparam int NS   = 3;
   localparam int HOLD = 16;
   localparam int GAP  = 8;
   localparam int CW   = 8;
   localparam int WDOG = 200;
   localparam int L    = HOLD + (NS - 1) * GAP;
   localparam int W    = NS + 3;

   logic clk;
   logic rst_n;

   rst_seq_if #(.NUM_STAGES(NS)) bus ();

   rst_seq_ctrl #(
      .NUM_STAGES  (NS),
      .HOLD_CYCLES (HOLD),
      .STAGE_GAP   (GAP),
      .CNT_W       (CW),
      .WDOG_CYCLES (WDOG)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // scoreboard: expected {stage_rst_n, seq_busy, seq_done, soft_rst_ack}
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_v;
   int           t     = 0;  // edges since the current sequence started
   int           klast = 0;  // t of the most recent kick in this sequence

   function automatic logic [W-1:0] model_out(input int tt, input logic ack);
      logic [NS-1:0] s;
      for (int k = 0; k < NS; k++) s[k] = (tt >= HOLD + k * GAP);
      return {s, (tt < L), (tt == L) && !ack, ack};
   endfunction

   function automatic logic [W-1:0] observed();
      return {bus.stage_rst_n, bus.seq_busy, bus.seq_done, bus.soft_rst_ack};
   endfunction

   // driver: apply inputs, clock one edge, advance the model, sample 1 time unit after the edge
   task automatic drive_edge(input logic rn, input logic req, input logic kick);
      logic trip;
      int   ref_t;
      rst_n            = rn;
      bus.soft_rst_req = req;
`ifdef RST_SEQ_WDOG_EN
      bus.wdog_kick    = kick;
`endif
      @(posedge clk);
      trip = 1'b0;
`ifdef RST_SEQ_WDOG_EN
      ref_t = (klast > L) ? klast : L;
      if (t >= L && !kick && (t + 1 - ref_t) == WDOG) trip = 1'b1;
`else
      ref_t = 0;
`endif
      if (!rn) begin
         t = 0; klast = 0;
         exp_q.push_back(model_out(0, 1'b0));
      end else if (req || trip) begin
         t = 0; klast = 0;
         exp_q.push_back(model_out(0, 1'b1));
      end else begin
         t = t + 1;
         if (kick) klast = t;
         exp_q.push_back(model_out(t, 1'b0));
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         drive_edge(1'b0, 1'b0, 1'b0);
         exp_v = exp_q.pop_front();
         n_checks++;
         if (observed() !== exp_v) begin
            n_fail++;
            $display("FAIL reset_hold cyc %0d: got %b want %b", i, observed(), exp_v);
         end
      end
      for (int e = 1; e <= 40; e++) begin
         drive_edge(1'b1, 1'b0, 1'b0);
         exp_v = exp_q.pop_front();
         n_checks++;
         if (observed() !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release edge %0d: got %b want %b", e, observed(), exp_v);
         end
         if (e == 15 || e == 16 || e == 24 || e == 32) begin
            n_checks++;
            if (bus.stage_rst_n !== ((e == 15) ? 3'b000 : (e == 16) ? 3'b001 : (e == 24) ? 3'b011 : 3'b111)) begin
               n_fail++;
               $display("FAIL release_point edge %0d: got stage %b", e, bus.stage_rst_n);
            end
         end
         if (e == 32) begin
            n_checks++;
            if (bus.seq_done !== 1'b1 || bus.seq_busy !== 1'b0) begin
               n_fail++;
               $display("FAIL last_release edge 32: got done %b busy %b want 1 0", bus.seq_done, bus.seq_busy);
            end
         end
      end
   endtask

   task automatic test_soft_in_run();
      for (int i = 0; i < 41; i++) begin
         drive_edge(1'b1, (i == 0), 1'b0);
         exp_v = exp_q.pop_front();
         n_checks++;
         if (observed() !== exp_v) begin
            n_fail++;
            $display("FAIL soft_in_run cyc %0d: got %b want %b", i, observed(), exp_v);
         end
      end
   endtask

   task automatic test_soft_mid();
      for (int i = 0; i < 67; i++) begin
         // reset edge, then 25 released edges, then the request lands on edge 26
         drive_edge((i != 0), (i == 26), 1'b0);
         exp_v = exp_q.pop_front();
         n_checks++;
         if (observed() !== exp_v) begin
            n_fail++;
            $display("FAIL soft_mid cyc %0d: got %b want %b", i, observed(), exp_v);
         end
      end
   endtask

   task automatic test_held_req();
      int acks = 0;
      for (int i = 0; i < 50; i++) begin
         drive_edge(1'b1, (i < 10), 1'b0);
         if (bus.soft_rst_ack === 1'b1) acks++;
         exp_v = exp_q.pop_front();
         n_checks++;
         if (observed() !== exp_v) begin
            n_fail++;
            $display("FAIL held_req cyc %0d: got %b want %b", i, observed(), exp_v);
         end
      end
      n_checks++;
      if (acks !== 10) begin
         n_fail++;
         $display("FAIL held_req_acks: got %0d want 10", acks);
      end
   endtask

   task automatic test_reset_with_req();
      for (int i = 0; i < 61; i++) begin
         // release at i=0 is a reset edge; edge 20 has rst_n low with the request high
         drive_edge((i != 0 && i != 20), (i == 20), 1'b0);
         exp_v = exp_q.pop_front();
         n_checks++;
         if (observed() !== exp_v) begin
            n_fail++;
            $display("FAIL reset_with_req cyc %0d: got %b want %b", i, observed(), exp_v);
         end
      end
   endtask

   task automatic test_random();
      logic rn, req, kick;
      for (int i = 0; i < 1500; i++) begin
         rn   = ($urandom_range(0, 149) != 0);
         req  = ($urandom_range(0, 59) == 0);
         kick = ($urandom_range(0, 99) == 0);
         drive_edge(rn, req, kick);
         exp_v = exp_q.pop_front();
         n_checks++;
         if (observed() !== exp_v) begin
            n_fail++;
            $display("FAIL random cyc %0d: got %b want %b", i, observed(), exp_v);
         end
      end
   endtask

`ifdef RST_SEQ_WDOG_EN
   task automatic test_watchdog();
      int trips = 0;
      drive_edge(1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      for (int i = 1; i <= L + WDOG + 10; i++) begin
         drive_edge(1'b1, 1'b0, 1'b0);
         if (bus.soft_rst_ack === 1'b1) trips++;
         exp_v = exp_q.pop_front();
         n_checks++;
         if (observed() !== exp_v) begin
            n_fail++;
            $display("FAIL wdog_timeout cyc %0d: got %b want %b", i, observed(), exp_v);
         end
      end
      n_checks++;
      if (trips !== 1) begin
         n_fail++;
         $display("FAIL wdog_trip_count: got %0d want 1", trips);
      end
      trips = 0;
      for (int i = 0; i < 2000; i++) begin
         drive_edge(1'b1, 1'b0, (i % 150) == 0);
         if (bus.soft_rst_ack === 1'b1) trips++;
         exp_v = exp_q.pop_front();
         n_checks++;
         if (observed() !== exp_v) begin
            n_fail++;
            $display("FAIL wdog_kicked cyc %0d: got %b want %b", i, observed(), exp_v);
         end
      end
      n_checks++;
      if (trips !== 0) begin
         n_fail++;
         $display("FAIL wdog_kicked_trips: got %0d want 0", trips);
      end
   endtask
`endif

   initial begin
      rst_n            = 1'b0;
      bus.soft_rst_req = 1'b0;
`ifdef RST_SEQ_WDOG_EN
      bus.wdog_kick    = 1'b0;
`endif
      test_reset();
      test_soft_in_run();
      test_soft_mid();
      test_held_req();
      test_reset_with_req();
      test_random();
`ifdef RST_SEQ_WDOG_EN
      test_watchdog();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
